// File: rtl/tx_rx_pkg.sv
// Shared types and defaults for the tx word serializer slice.
package tx_rx_pkg;

   typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;

   localparam int SER_WIDTH = 8;
   localparam int SER_DEPTH = 4;

   // Pointer width for a DEPTH-entry FIFO; a 1-entry FIFO still needs one bit.
   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/tx_word_serializer_if.sv
// Word-in / bit-out port bundle of the serializer; master is the environment side.
interface tx_word_serializer_if
   import tx_rx_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH,
   parameter int DEPTH = SER_DEPTH
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic             ser_data;
   logic             ser_valid;
   logic             ser_ready;
   logic             frame_done;
   logic [CW-1:0]    fifo_count;

   modport master (
      output in_data, in_valid, in_last, ser_ready,
      input  in_ready, ser_data, ser_valid, frame_done, fifo_count
   );

   modport slave (
      input  in_data, in_valid, in_last, ser_ready,
      output in_ready, ser_data, ser_valid, frame_done, fifo_count
   );

endinterface

// File: rtl/tx_word_fifo.sv
// Show-ahead synchronous FIFO; rdata always reflects the entry at the read pointer.
module tx_word_fifo
   import tx_rx_pkg::*;
#(
   parameter int W     = SER_WIDTH + 1,
   parameter int DEPTH = SER_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = ptr_bits(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tx_word_serializer.sv
// Buffers parallel words and shifts them out MSB-first on a 1-bit valid/ready link.
module tx_word_serializer
   import tx_rx_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH,
   parameter int DEPTH = SER_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   tx_word_serializer_if.slave bus
);
   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   ser_state_e       state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bitcnt;
   logic             last_q;
   logic             ser_valid_q;
   logic             frame_done_q;

   logic [WIDTH:0]   rdata;
   logic [CW-1:0]    count;
   logic             full, empty;
   logic             push, pop, xfer, word_end;

   assign push     = bus.in_valid && bus.in_ready;
   assign xfer     = ser_valid_q && bus.ser_ready;
   assign word_end = xfer && (bitcnt == BIT_LAST);
   // Pop when idle with data waiting, or on the final bit so the next word follows with no bubble.
   assign pop      = !empty && ((state == S_IDLE) || (state == S_SHIFT && word_end));

   tx_word_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({bus.in_last, bus.in_data}),
      .rdata (rdata),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Serializer FSM: loads words from the FIFO, shifts on each accepted bit, flags frame ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         shreg        <= '0;
         bitcnt       <= '0;
         last_q       <= 1'b0;
         ser_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  shreg       <= rdata[WIDTH-1:0];
                  last_q      <= rdata[WIDTH];
                  bitcnt      <= '0;
                  ser_valid_q <= 1'b1;
                  state       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (xfer) begin
                  shreg  <= shreg << 1;
                  bitcnt <= bitcnt + 1'b1;
               end
               if (word_end) begin
                  frame_done_q <= last_q;
                  if (!empty) begin
                     shreg  <= rdata[WIDTH-1:0];
                     last_q <= rdata[WIDTH];
                     bitcnt <= '0;
                  end else begin
                     ser_valid_q <= 1'b0;
                     state       <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = !full;
   assign bus.ser_data   = shreg[WIDTH-1];
   assign bus.ser_valid  = ser_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.fifo_count = count;

endmodule

// File: tb/tb_tx_word_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-stream model.
module tb_tx_word_serializer;
   localparam int W = 8;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tx_word_serializer_if #(.WIDTH(W), .DEPTH(D)) bus ();

   tx_word_serializer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic b;
      logic frame_end;
   } bit_t;

   // Reference model: expected link bits in order plus occupancy bookkeeping.
   bit_t bq[$];
   int   acc, bits, m_count, cyc;
   logic m_valid, m_fd;
   int   n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      chk("in_ready",   32'(bus.in_ready),   32'(m_count < D));
      chk("ser_valid",  32'(bus.ser_valid),  32'(m_valid));
      chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
      chk("fifo_count", 32'(bus.fifo_count), 32'(m_count));
      if (m_valid && bq.size() > 0) chk("ser_data", 32'(bus.ser_data), 32'(bq[0].b));
   endtask

   task automatic model_reset();
      bq.delete();
      acc = 0; bits = 0; m_count = 0; m_valid = 1'b0; m_fd = 1'b0;
   endtask

   // One clock: drive inputs, advance the model across the edge, check at the next negedge.
   task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
      logic push, xfer, pv;
      int   pcount;
      bit_t e;
      bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.ser_ready = r;
      pcount = m_count;
      pv     = m_valid;
      push   = v && (m_count < D);
      xfer   = m_valid && r;
      m_fd   = 1'b0;
      if (push) begin
         acc++;
         for (int i = W - 1; i >= 0; i--) begin
            e.b = d[i];
            e.frame_end = (i == 0) && l;
            bq.push_back(e);
         end
      end
      if (xfer) begin
         e = bq.pop_front();
         bits++;
         m_fd = e.frame_end;
      end
      // Mid-word the link stays valid; at a word boundary it is valid if a stalled first bit
      // is still waiting, or if the buffer held a word going into this edge.
      if (bits % W != 0)  m_valid = 1'b1;
      else if (pv && !r)  m_valid = 1'b1;
      else                m_valid = (pcount > 0);
      m_count = acc - ((bits + W - 1) / W + ((bits % W == 0 && m_valid) ? 1 : 0));
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_outputs();
   endtask

   initial begin
      int fd_t[$];
      int vcnt;
      logic [W-1:0] rd;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.ser_ready = 1'b0;
      cyc = 0;
      model_reset();
      do_reset();

      // Single word, free-running link.
      step(1'b1, 8'hA5, 1'b1, 1'b1);
      repeat (11) step(1'b0, '0, 1'b0, 1'b1);

      // Backpressure with a 1,0,0,1 ready pattern.
      step(1'b1, 8'hC3, 1'b1, 1'b1);
      for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b0, (i % 4 == 0) || (i % 4 == 3));

      // Fill with the link stalled, one push refused, then drain.
      for (int i = 0; i < 6; i++) step(1'b1, W'(8'h11 * (i + 1)), i[0], 1'b0);
      chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (45) step(1'b0, '0, 1'b0, 1'b1);

      // Back-to-back single-word frames.
      vcnt = 0;
      step(1'b1, 8'hFF, 1'b1, 1'b1);
      step(1'b1, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 22; i++) begin
         if (bus.ser_valid) vcnt++;
         if (bus.frame_done) fd_t.push_back(cyc);
         step(1'b0, '0, 1'b0, 1'b1);
      end
      chk("b2b_valid_cycles", 32'(vcnt), 32'd16);
      chk("b2b_pulses", 32'(fd_t.size()), 32'd2);
      if (fd_t.size() == 2) chk("b2b_gap", 32'(fd_t[1] - fd_t[0]), 32'd8);

      // Hold occupancy at 2 with continuous push/pop, then enough words to wrap pointers.
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b1, 8'h96, 1'b0, 1'b0);
      for (int i = 0; i < 3 * D * W; i++) begin
         rd = W'($urandom);
         step(i % W == 0, rd, 1'b0, 1'b1);
      end
      repeat (40) step(1'b0, '0, 1'b0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         rd = W'($urandom);
         step($urandom_range(0, 3) == 0, rd, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      end

      // Reset in the middle of a word, then confirm nothing stale comes out.
      step(1'b1, 8'hE7, 1'b1, 1'b1);
      step(1'b1, 8'h18, 1'b1, 1'b1);
      repeat (3) step(1'b0, '0, 1'b0, 1'b1);
      do_reset();
      repeat (10) step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 8'h81, 1'b1, 1'b1);
      repeat (12) step(1'b0, '0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
